// File: rtl/gfsk_tx_controller.sv
// Front-end sequencer for gfsk_modulation: loads the Gaussian FIR taps, then
// serialises a length-prefixed byte stream (LSB first) at one bit per symbol
// period and waits for the modulator to drain before reporting completion.
module gfsk_tx_controller #(
  parameter int unsigned SAMPLE_PER_SYMBOL      = 8,
  parameter int unsigned GAUSS_FILTER_BIT_WIDTH = 16,
  parameter int unsigned NUM_UNIQUE_TAP         = 9,
  parameter int unsigned DRAIN_TIMEOUT          = 256
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     cfg_start,
  input  logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] tap_in_value,
  input  logic                                     tap_in_valid,
  output logic                                     tap_in_ready,
  output logic                                     cfg_done,
  output logic        [3:0]                        gauss_filter_tap_index,
  output logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] gauss_filter_tap_value,
  input  logic                                     tx_start,
  input  logic        [7:0]                        tx_len,
  input  logic        [7:0]                        byte_in,
  input  logic                                     byte_in_valid,
  output logic                                     byte_in_ready,
  output logic                                     phy_bit,
  output logic                                     bit_valid,
  output logic                                     bit_valid_last,
  input  logic                                     mod_valid_last,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err
);

  localparam int unsigned SymW   = (SAMPLE_PER_SYMBOL > 2) ? $clog2(SAMPLE_PER_SYMBOL) : 1;
  localparam int unsigned DrainW = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [SymW-1:0]   SymLast   = SymW'(SAMPLE_PER_SYMBOL - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0]        TapLast   = 4'(NUM_UNIQUE_TAP - 1);

  typedef enum logic [2:0] {StIdle, StCfg, StLoad, StSend, StDrain} state_e;

  state_e                                state_q, state_d;
  logic        [3:0]                     tap_cnt_q, tap_cnt_d;
  logic                                  cfg_done_q, cfg_done_d;
  logic        [3:0]                     tap_idx_q, tap_idx_d;
  logic signed [GAUSS_FILTER_BIT_WIDTH-1:0] tap_val_q, tap_val_d;
  logic        [7:0]                     shift_q, shift_d;
  logic        [7:0]                     buf_q, buf_d;
  logic                                  buf_full_q, buf_full_d;
  logic        [2:0]                     bit_cnt_q, bit_cnt_d;
  logic        [SymW-1:0]                sym_cnt_q, sym_cnt_d;
  logic        [7:0]                     rem_q, rem_d;  // bytes not yet fetched
  logic        [DrainW-1:0]              drain_cnt_q, drain_cnt_d;
  logic                                  done_q, done_d;
  logic                                  err_q, err_d;

  logic tap_hs, byte_rdy, byte_hs, sym_wrap, in_send;

  assign in_send  = (state_q == StSend);
  assign tap_hs   = (state_q == StCfg) && tap_in_valid;
  assign byte_rdy = (state_q == StLoad) || (in_send && !buf_full_q && (rem_q != 8'd0));
  assign byte_hs  = byte_rdy && byte_in_valid;
  assign sym_wrap = (sym_cnt_q == SymLast);

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    tap_cnt_d   = tap_cnt_q;
    cfg_done_d  = cfg_done_q;
    tap_idx_d   = tap_idx_q;
    tap_val_d   = tap_val_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    bit_cnt_d   = bit_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    rem_d       = rem_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d    = StCfg;
          tap_cnt_d  = 4'd0;
          cfg_done_d = 1'b0;
        end else if (tx_start && cfg_done_q && (tx_len != 8'd0)) begin
          state_d = StLoad;
          rem_d   = tx_len;
        end
      end
      StCfg: begin
        if (tap_hs) begin
          tap_idx_d = tap_cnt_q;
          tap_val_d = tap_in_value;
          tap_cnt_d = tap_cnt_q + 4'd1;
          if (tap_cnt_q == TapLast) begin
            cfg_done_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      StLoad: begin
        if (byte_hs) begin
          shift_d   = byte_in;
          bit_cnt_d = 3'd0;
          sym_cnt_d = '0;
          rem_d     = rem_q - 8'd1;
          state_d   = StSend;
        end
      end
      StSend: begin
        sym_cnt_d = sym_wrap ? '0 : sym_cnt_q + 1'b1;
        if (byte_hs) begin
          buf_d      = byte_in;
          buf_full_d = 1'b1;
          rem_d      = rem_q - 8'd1;
        end
        if (sym_wrap) begin
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (buf_full_q) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            bit_cnt_d  = 3'd0;
          end else if (byte_hs) begin
            // Byte arrived on the very last cycle: use it directly, no underrun.
            shift_d    = byte_in;
            buf_full_d = 1'b0;
            bit_cnt_d  = 3'd0;
          end else if (rem_q != 8'd0) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d     = StDrain;
            drain_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (mod_valid_last) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (drain_cnt_q == DrainLast) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      tap_cnt_q   <= 4'd0;
      cfg_done_q  <= 1'b0;
      tap_idx_q   <= 4'd0;
      tap_val_q   <= '0;
      shift_q     <= 8'd0;
      buf_q       <= 8'd0;
      buf_full_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
      sym_cnt_q   <= '0;
      rem_q       <= 8'd0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      cfg_done_q  <= cfg_done_d;
      tap_idx_q   <= tap_idx_d;
      tap_val_q   <= tap_val_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      bit_cnt_q   <= bit_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      rem_q       <= rem_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    tap_in_ready           = (state_q == StCfg);
    cfg_done               = cfg_done_q;
    gauss_filter_tap_index = tap_idx_q;
    gauss_filter_tap_value = tap_val_q;
    byte_in_ready          = byte_rdy;
    phy_bit                = in_send & shift_q[bit_cnt_q];
    bit_valid              = in_send && (sym_cnt_q == '0);
    // Final bit: last bit of a byte with nothing fetched or buffered behind it.
    bit_valid_last         = bit_valid && (bit_cnt_q == 3'd7) && (rem_q == 8'd0) && !buf_full_q;
    busy                   = (state_q != StIdle);
    done                   = done_q;
    err                    = err_q;
  end

endmodule

// File: tb/tb_gfsk_tx_controller.sv
// Directed bench for gfsk_tx_controller: tap-load and packet vector tables plus
// hand-written reset and ignored-start sequences.
module tb_gfsk_tx_controller;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_start;
  logic signed [15:0] tap_in_value;
  logic               tap_in_valid;
  logic               tap_in_ready;
  logic               cfg_done;
  logic        [3:0]  gauss_filter_tap_index;
  logic signed [15:0] gauss_filter_tap_value;
  logic               tx_start;
  logic        [7:0]  tx_len;
  logic        [7:0]  byte_in;
  logic               byte_in_valid;
  logic               byte_in_ready;
  logic               phy_bit;
  logic               bit_valid;
  logic               bit_valid_last;
  logic               mod_valid_last;
  logic               busy;
  logic               done;
  logic               err;

  gfsk_tx_controller #(
    .SAMPLE_PER_SYMBOL     (8),
    .GAUSS_FILTER_BIT_WIDTH(16),
    .NUM_UNIQUE_TAP        (9),
    .DRAIN_TIMEOUT         (256)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cfg_start             (cfg_start),
    .tap_in_value          (tap_in_value),
    .tap_in_valid          (tap_in_valid),
    .tap_in_ready          (tap_in_ready),
    .cfg_done              (cfg_done),
    .gauss_filter_tap_index(gauss_filter_tap_index),
    .gauss_filter_tap_value(gauss_filter_tap_value),
    .tx_start              (tx_start),
    .tx_len                (tx_len),
    .byte_in               (byte_in),
    .byte_in_valid         (byte_in_valid),
    .byte_in_ready         (byte_in_ready),
    .phy_bit               (phy_bit),
    .bit_valid             (bit_valid),
    .bit_valid_last        (bit_valid_last),
    .mod_valid_last        (mod_valid_last),
    .busy                  (busy),
    .done                  (done),
    .err                   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tap;
    logic [3:0]  idx;
    logic        cfg_done;
  } tap_vec_t;

  typedef struct {
    int          len;
    int          supply;    // bytes the host will offer
    logic [7:0]  b0, b1, b2;
    int          mvl;       // cycles after bit_valid_last to pulse mod_valid_last, -1 = never
    int          pulses;
    logic [23:0] bits;      // bit i = phy_bit at pulse i
    logic [23:0] lasts;     // bit i = bit_valid_last at pulse i
    int          hs;
    int          done_cyc;  // cycle (0 = first LOAD cycle) where done is seen
    logic        err;
  } pkt_vec_t;

  tap_vec_t tap_tab [9];
  pkt_vec_t pkt_tab [4];

  int checks = 0;
  int errors = 0;

  logic [7:0]  pkt_bytes [3];
  int          n_pulse, n_hs, done_cyc, spacing_bad;
  logic [23:0] got_bits, got_lasts;
  logic        done_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [28:0] all_outs();
    return {tap_in_ready, cfg_done, gauss_filter_tap_index, gauss_filter_tap_value,
            byte_in_ready, phy_bit, bit_valid, bit_valid_last, busy, done, err};
  endfunction

  // Starts a packet and runs it to done (or budget), recording the bit stream.
  task automatic run_packet(input int len, input int supply, input int mvl, input int budget);
    int  c;
    int  fed;
    int  last_cyc;
    int  prev_cyc;
    bit  hs;
    bit  fin;
    c = 0; fed = 0; last_cyc = -1; prev_cyc = -7; fin = 0;
    n_pulse = 0; n_hs = 0; done_cyc = -1; done_err = 1'b0; spacing_bad = 0;
    got_bits = '0; got_lasts = '0;
    tx_len   = 8'(len);
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    while (c < budget && !fin) begin
      if (bit_valid) begin
        if (c != prev_cyc + 8) spacing_bad++;
        prev_cyc = c;
        if (n_pulse < 24) begin
          got_bits[n_pulse]  = phy_bit;
          got_lasts[n_pulse] = bit_valid_last;
        end
        if (bit_valid_last) last_cyc = c;
        n_pulse++;
      end
      if (done) begin
        done_cyc = c;
        done_err = err;
        fin = 1;
      end
      mod_valid_last = (mvl >= 0) && (last_cyc >= 0) && (c == last_cyc + mvl);
      byte_in_valid  = (fed < supply);
      byte_in        = (fed < supply) ? pkt_bytes[fed] : 8'h00;
      hs = byte_in_valid && byte_in_ready;
      if (!fin) begin
        tick();
        if (hs) begin
          fed++;
          n_hs++;
        end
        c++;
      end
    end
    byte_in_valid  = 1'b0;
    mod_valid_last = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 9; i++) tap_tab[i] = '{16'(16 * (i + 1)), 4'(i), (i == 8)};
    pkt_tab[0] = '{1, 1, 8'hA5, 8'h00, 8'h00, 20, 8, 24'h0000A5, 24'h000080, 1, 78, 1'b0};
    pkt_tab[1] = '{3, 3, 8'h01, 8'h80, 8'hFF, 10, 24, 24'hFF8001, 24'h800000, 3, 196, 1'b0};
    pkt_tab[2] = '{2, 1, 8'h3C, 8'h77, 8'h00, -1, 8, 24'h00003C, 24'h000000, 1, 65, 1'b1};
    pkt_tab[3] = '{1, 1, 8'h5A, 8'h00, 8'h00, -1, 8, 24'h00005A, 24'h000080, 1, 321, 1'b1};

    rst = 1'b1; cfg_start = 1'b0; tap_in_value = '0; tap_in_valid = 1'b0;
    tx_start = 1'b0; tx_len = 8'd0; byte_in = 8'd0; byte_in_valid = 1'b0;
    mod_valid_last = 1'b0;
    repeat (3) tick();
    check("reset outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    tick();
    check("idle after reset", 64'(all_outs()), 64'd0);

    // tx_start without configuration is ignored
    begin
      logic seen;
      seen = 1'b0;
      tx_len = 8'd1; tx_start = 1'b1; byte_in = 8'hFF; byte_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        tx_start = 1'b0;
        seen |= busy | bit_valid | done | byte_in_ready;
      end
      byte_in_valid = 1'b0;
      check("start without cfg ignored", 64'(seen), 64'd0);
    end

    // Tap load, one idle cycle between taps
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("tap ready in cfg", 64'(tap_in_ready), 64'd1);
    for (int i = 0; i < 9; i++) begin
      tap_in_value = tap_tab[i].tap;
      tap_in_valid = 1'b1;
      tick();
      tap_in_valid = 1'b0;
      check($sformatf("tap%0d index", i), 64'(gauss_filter_tap_index), 64'(tap_tab[i].idx));
      check($sformatf("tap%0d value", i), 64'(gauss_filter_tap_value), 64'(tap_tab[i].tap));
      check($sformatf("tap%0d cfg_done", i), 64'(cfg_done), 64'(tap_tab[i].cfg_done));
      tick();
    end
    check("tap ready in idle", 64'(tap_in_ready), 64'd0);
    check("tap value held", 64'(gauss_filter_tap_value), 64'h0090);

    // tx_len = 0 is ignored even when configured
    begin
      logic seen;
      seen = 1'b0;
      tx_len = 8'd0; tx_start = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        tx_start = 1'b0;
        seen |= busy | bit_valid | done;
      end
      check("zero length ignored", 64'(seen), 64'd0);
    end

    // Packet vectors
    for (int r = 0; r < 4; r++) begin
      pkt_bytes[0] = pkt_tab[r].b0;
      pkt_bytes[1] = pkt_tab[r].b1;
      pkt_bytes[2] = pkt_tab[r].b2;
      run_packet(pkt_tab[r].len, pkt_tab[r].supply, pkt_tab[r].mvl, 400);
      check($sformatf("pkt%0d pulses", r), 64'(n_pulse), 64'(pkt_tab[r].pulses));
      check($sformatf("pkt%0d bits", r), 64'(got_bits), 64'(pkt_tab[r].bits));
      check($sformatf("pkt%0d last flags", r), 64'(got_lasts), 64'(pkt_tab[r].lasts));
      check($sformatf("pkt%0d pacing", r), 64'(spacing_bad), 64'd0);
      check($sformatf("pkt%0d handshakes", r), 64'(n_hs), 64'(pkt_tab[r].hs));
      check($sformatf("pkt%0d done cycle", r), 64'(done_cyc), 64'(pkt_tab[r].done_cyc));
      check($sformatf("pkt%0d err", r), 64'(done_err), 64'(pkt_tab[r].err));
      check($sformatf("pkt%0d busy at done", r), 64'(busy), 64'd0);
      tick();
      check($sformatf("pkt%0d done pulse width", r), 64'(done), 64'd0);
      tick();
    end

    // Reset in the middle of SEND
    tx_len = 8'd1; tx_start = 1'b1;
    tick();
    tx_start = 1'b0; byte_in = 8'hFF; byte_in_valid = 1'b1;
    tick();
    byte_in_valid = 1'b0;
    repeat (3) tick();
    check("busy before mid reset", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    check("mid-send reset outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    tick();
    check("idle after mid reset", 64'({busy, cfg_done, bit_valid}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfsk_tx_controller.md
Name: gfsk_tx_controller

Overview:
Sequencer in front of gfsk_modulation. It loads the 9 unique Gaussian FIR taps, then serialises a length-prefixed packet byte stream into phy_bit/bit_valid/bit_valid_last, pacing one bit per SAMPLE_PER_SYMBOL clocks. After the last bit it waits for the modulator's filtered-output valid_last and then reports completion, or a timeout/underrun error.

Parameters:
SAMPLE_PER_SYMBOL, 8, clocks per bit; must match gfsk_modulation; ≥2
GAUSS_FILTER_BIT_WIDTH, 16, tap width
NUM_UNIQUE_TAP, 9, taps written (index 0..8)
DRAIN_TIMEOUT, 256, max clocks waiting for mod_valid_last

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_start  in  1  begin tap load (IDLE only)
tap_in_value  in  GAUSS_FILTER_BIT_WIDTH  signed tap from host
tap_in_valid  in  1  tap handshake valid
tap_in_ready  out  1  tap handshake ready
cfg_done  out  1  taps loaded (sticky)
gauss_filter_tap_index  out  4  to modulator
gauss_filter_tap_value  out  GAUSS_FILTER_BIT_WIDTH  to modulator
tx_start  in  1  start packet (IDLE, cfg_done=1)
tx_len  in  8  packet length in bytes, 1..255
byte_in  in  8  packet byte, sent LSB first
byte_in_valid  in  1  byte handshake valid
byte_in_ready  out  1  byte handshake ready
phy_bit  out  1  to modulator
bit_valid  out  1  to modulator
bit_valid_last  out  1  to modulator
mod_valid_last  in  1  bit_upsample_gauss_filter_valid_last from modulator
busy  out  1  state != IDLE
done  out  1  1-cycle completion pulse
err  out  1  1-cycle pulse with done on underrun/timeout

Behaviour:
- Reset (synchronous, active-high, wins over all inputs, also mid-operation): state=IDLE. All outputs 0, including cfg_done, tap index/value, phy_bit, bit_valid, bit_valid_last, ready signals, done and err. Prefetch buffer emptied; all counters 0.
- States: IDLE, CFG, LOAD, SEND, DRAIN.
- IDLE:
  - cfg_start → CFG, tap_cnt=0, cfg_done cleared.
  - Otherwise, tx_start && cfg_done && tx_len!=0 → LOAD, and rem_bytes=tx_len is latched.
  - cfg_start has priority when both starts are high.
  - tx_start is ignored if cfg_done=0 or tx_len=0.
- CFG:
  - tap_in_ready=1.
  - On each handshake, register gauss_filter_tap_index=tap_cnt and gauss_filter_tap_value=tap_in_value (visible next cycle), then tap_cnt++.
  - After the handshake with tap_cnt=8: cfg_done=1, state → IDLE.
  - Tap outputs hold their last written value afterwards.
- LOAD:
  - byte_in_ready=1.
  - On handshake: shift_reg=byte_in, bit_cnt=0, sym_cnt=0, rem_bytes--, state → SEND.
- SEND:
  - sym_cnt counts 0..SAMPLE_PER_SYMBOL-1 and wraps.
  - bit_valid is a registered pulse in the cycle where sym_cnt==0, so the first pulse lands in the first SEND cycle (one clock after the LOAD handshake).
  - phy_bit=shift_reg[bit_cnt], held stable for the whole symbol.
  - Prefetch: byte_in_ready=1 while the 1-entry buffer is empty and the number of bytes not yet fetched is >0. The handshake fills the buffer.
  - At the end of a byte's bit 7 symbol (sym_cnt wrap, bit_cnt=7):
    - bytes remain and buffer full → shift_reg=buffer, buffer empty, bit_cnt=0, no gap in bit pacing;
    - bytes remain and buffer empty → underrun: done=1, err=1, state → IDLE, no bit_valid_last issued.
  - bit_valid_last=1 together with the bit_valid of bit 7 of the final byte. At that symbol's wrap, state → DRAIN, drain_cnt=0.
- DRAIN:
  - mod_valid_last=1 → done=1, state → IDLE.
  - drain_cnt reaching DRAIN_TIMEOUT-1 without mod_valid_last → done=1, err=1, state → IDLE.
  - mod_valid_last outside DRAIN is ignored.
- cfg_start and tx_start outside IDLE are ignored.
- Bit count per packet is exactly 8*tx_len bit_valid pulses.

Test Plan:
- Reset, then tap load: feed taps 0x0010..0x0090 with one idle cycle between each → tap index steps 0..8 with values matching; cfg_done=1 after the 9th; tap_in_ready=0 in IDLE.
- tx_start with cfg_done=0, and tx_len=0 with cfg_done=1 → busy stays 0, no bit_valid, no done.
- tx_len=1, byte 0xA5, SPS=8 → 8 bit_valid pulses 8 clocks apart; phy_bit sequence 1,0,1,0,0,1,0,1; bit_valid_last only on the 8th pulse. mod_valid_last 20 clocks later → done=1, err=0 in the following cycle.
- tx_len=3, bytes 0x01,0x80,0xFF all presented immediately → 24 pulses with no gaps, exactly 3 byte handshakes, bit_valid_last on pulse 24.
- tx_len=2, second byte withheld → err=1 and done=1 at the end of byte 1's last symbol; bit_valid_last never asserted; busy=0.
- mod_valid_last never arrives → done=err=1 exactly DRAIN_TIMEOUT clocks after DRAIN entry. Separately, rst asserted mid-SEND → all outputs 0 next cycle and cfg_done=0.
